// File: rtl/pc_sequencer.sv
// Fetch-PC sequencer: selects sequential, branch or jump next-PC, parks
// redirects that arrive while instruction memory is busy, and counts redirects.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        br_taken,
  input  logic        jump,
  input  logic [31:0] br_pc4,
  input  logic [15:0] br_imm,
  input  logic [25:0] j_index,
  output logic [31:0] pc,
  output logic [1:0]  pc_sel,
  output logic        fetch_req,
  output logic        flush,
  output logic [15:0] redirect_cnt
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_e;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_J   = 2'b10;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [1:0]  pend_sel_q, pend_sel_d;
  logic        flush_q, flush_d;
  logic [15:0] cnt_q, cnt_d;

  logic [31:0] seq_s, br_tgt_s, j_tgt_s, redir_tgt_s;
  logic [1:0]  sel_s, redir_sel_s;
  logic        fetch_s, redir_s, applied_s;

  // Candidate next-PC values, all wrapping modulo 2^32
  always_comb begin
    seq_s    = pc_q + 32'd4;
    br_tgt_s = br_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
    j_tgt_s  = {br_pc4[31:28], j_index, 2'b00};
  end

  // Redirect arbitration: jump wins over branch
  always_comb begin
    redir_s = jump | br_taken;
    if (jump) begin
      redir_tgt_s = j_tgt_s;
      redir_sel_s = SEL_J;
    end else if (br_taken) begin
      redir_tgt_s = br_tgt_s;
      redir_sel_s = SEL_BR;
    end else begin
      redir_tgt_s = seq_s;
      redir_sel_s = SEL_SEQ;
    end
  end

  // Next-state, next-PC and select logic
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    pend_sel_d = pend_sel_q;
    flush_d    = 1'b0;
    applied_s  = 1'b0;
    sel_s      = SEL_SEQ;
    fetch_s    = 1'b0;
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        fetch_s = 1'b1;
        sel_s   = redir_sel_s;
        if (redir_s) begin
          if (imem_ready) begin
            pc_d      = redir_tgt_s;
            flush_d   = 1'b1;
            applied_s = 1'b1;
          end else begin
            pend_tgt_d = redir_tgt_s;
            pend_sel_d = redir_sel_s;
            state_d    = S_PEND;
          end
        end else if (imem_ready && !stall) begin
          pc_d = seq_s;
        end else begin
          pc_d = pc_q;
        end
      end
      S_PEND: begin
        // New redirects and stalls are ignored until the parked one lands
        fetch_s = 1'b1;
        sel_s   = pend_sel_q;
        if (imem_ready) begin
          pc_d       = pend_tgt_q;
          flush_d    = 1'b1;
          applied_s  = 1'b1;
          pend_tgt_d = 32'h0000_0000;
          pend_sel_d = SEL_SEQ;
          state_d    = S_RUN;
        end else begin
          state_d = S_PEND;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
    if (applied_s && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Reset forces the combinational outputs quiet in the reset cycle itself
  always_comb begin
    if (reset) begin
      pc_sel    = SEL_SEQ;
      fetch_req = 1'b0;
    end else begin
      pc_sel    = sel_s;
      fetch_req = fetch_s;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      pend_tgt_q <= 32'h0000_0000;
      pend_sel_q <= SEL_SEQ;
      flush_q    <= 1'b0;
      cnt_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      pend_sel_q <= pend_sel_d;
      flush_q    <= flush_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc           = pc_q;
  assign flush        = flush_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic
// compared against a behavioural next-PC model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, imem_ready, stall, br_taken, jump;
  logic [31:0] br_pc4;
  logic [15:0] br_imm;
  logic [25:0] j_index;
  logic [31:0] pc;
  logic [1:0]  pc_sel;
  logic        fetch_req, flush;
  logic [15:0] redirect_cnt;

  int n_checks = 0;
  int n_bad    = 0;

  // Behavioural model: a boot flag, an optional parked redirect, and counters
  logic [31:0] m_pc    = 32'h0;
  bit          m_boot  = 1'b1;
  bit          m_flush = 1'b0;
  int          m_cnt   = 0;
  logic [33:0] m_pend[$];

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_ready(imem_ready), .stall(stall),
    .br_taken(br_taken), .jump(jump), .br_pc4(br_pc4), .br_imm(br_imm),
    .j_index(j_index), .pc(pc), .pc_sel(pc_sel), .fetch_req(fetch_req),
    .flush(flush), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] br_target(input logic [31:0] p4, input logic [15:0] imm);
    int off;
    off = int'($signed(imm)) * 4;
    return p4 + 32'(off);
  endfunction

  function automatic logic [31:0] j_target(input logic [31:0] p4, input logic [25:0] ji);
    return (p4 & 32'hF000_0000) | (32'(ji) * 32'd4);
  endfunction

  // Drive one cycle of inputs, check select/fetch, clock, then check state outputs
  task automatic step(input bit r, input bit rdy, input bit st, input bit br, input bit j,
                      input logic [31:0] p4, input logic [15:0] imm, input logic [25:0] ji);
    logic [31:0] tgt;
    logic [1:0]  e_sel;
    bit          e_fetch;
    reset = r; imem_ready = rdy; stall = st; br_taken = br; jump = j;
    br_pc4 = p4; br_imm = imm; j_index = ji;
    #1;
    if (r || m_boot) begin
      e_sel = 2'b00; e_fetch = 1'b0;
    end else if (m_pend.size() != 0) begin
      e_sel = m_pend[0][33:32]; e_fetch = 1'b1;
    end else begin
      e_sel = j ? 2'b10 : (br ? 2'b01 : 2'b00); e_fetch = 1'b1;
    end
    check_val("pc_sel", {30'd0, pc_sel}, {30'd0, e_sel});
    check_val("fetch_req", {31'd0, fetch_req}, {31'd0, e_fetch});
    @(posedge clk);
    m_flush = 1'b0;
    if (r) begin
      m_pc = 32'h0; m_boot = 1'b1; m_cnt = 0; m_pend.delete();
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_pend.size() != 0) begin
      if (rdy) begin
        m_pc = m_pend[0][31:0]; m_pend.delete(); m_flush = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end
    end else if (j || br) begin
      tgt = j ? j_target(p4, ji) : br_target(p4, imm);
      if (rdy) begin
        m_pc = tgt; m_flush = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_pend.push_back({e_sel, tgt});
      end
    end else if (rdy && !st) begin
      m_pc = m_pc + 32'd4;
    end
    #1;
    check_val("pc", pc, m_pc);
    check_val("flush", {31'd0, flush}, {31'd0, m_flush});
    check_val("redirect_cnt", {16'd0, redirect_cnt}, 32'(m_cnt));
  endtask

  task automatic seq_step(input bit rdy, input bit st);
    step(1'b0, rdy, st, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; stall = 1'b0; br_taken = 1'b0; jump = 1'b0;
    br_pc4 = 32'h0; br_imm = 16'h0; j_index = 26'h0;
    #1;
    // Reset release and sequential fetch: 0 (boot), 0, 4, 8, 12
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
    check_val("rst_pc", pc, 32'h0);
    check_val("rst_cnt", {16'd0, redirect_cnt}, 32'h0);
    seq_step(1'b1, 1'b0);
    check_val("boot_pc", pc, 32'h0);
    seq_step(1'b1, 1'b0);
    check_val("seq_pc4", pc, 32'h4);
    seq_step(1'b1, 1'b0);
    seq_step(1'b1, 1'b0);
    check_val("seq_pc12", pc, 32'hC);
    for (int i = 0; i < 13; i++) seq_step(1'b1, 1'b0);
    check_val("pc_at_40", pc, 32'h40);
    // Backward branch from 0x40
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h44, 16'hFFFE, 26'h0);
    check_val("br_pc", pc, 32'h3C);
    check_val("br_flush", {31'd0, flush}, 32'h1);
    check_val("br_cnt", {16'd0, redirect_cnt}, 32'h1);
    seq_step(1'b1, 1'b1);
    check_val("flush_one_cycle", {31'd0, flush}, 32'h0);
    // Jump beats branch, counted once
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA000_0010, 16'h0010, 26'h000_0100);
    check_val("jmp_pc", pc, 32'hA000_0400);
    check_val("jmp_cnt", {16'd0, redirect_cnt}, 32'h2);
    // Jump while memory busy for 3 cycles; later branch in PEND is ignored
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000_0000, 16'h0, 26'h000_0020);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 16'h0004, 26'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 16'h0004, 26'h3);
    check_val("pend_hold_pc", pc, 32'hA000_0400);
    check_val("pend_sel", {30'd0, pc_sel}, 32'h2);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0300, 16'h0008, 26'h0);
    check_val("pend_load_pc", pc, 32'h1000_0080);
    check_val("pend_flush", {31'd0, flush}, 32'h1);
    // Stall with branch: branch applied; stall alone holds
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_2000, 16'h0004, 26'h0);
    check_val("stall_br_pc", pc, 32'h0000_2010);
    seq_step(1'b1, 1'b1);
    seq_step(1'b1, 1'b1);
    check_val("stall_hold_pc", pc, 32'h0000_2010);
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
           $urandom, 16'($urandom), 26'($urandom));
    end
    // Counter saturation
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
    seq_step(1'b1, 1'b0);
    for (int i = 0; i < 65534; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, $urandom, 16'h0, 26'($urandom));
    end
    check_val("cnt_fffe", {16'd0, redirect_cnt}, 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_4000, 16'h0001, 26'h0);
    end
    check_val("cnt_sat", {16'd0, redirect_cnt}, 32'h0000_FFFF);
    // Reset while a redirect is parked discards it
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3000_0000, 16'h0, 26'h000_0040);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 16'h0, 26'h0);
    check_val("pend_rst_pc", pc, 32'h0);
    check_val("pend_rst_cnt", {16'd0, redirect_cnt}, 32'h0);
    seq_step(1'b1, 1'b0);
    check_val("pend_discard_pc", pc, 32'h0);
    check_val("pend_discard_flush", {31'd0, flush}, 32'h0);
    seq_step(1'b1, 1'b0);
    check_val("post_rst_seq", pc, 32'h4);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-004 SHALL provide port imem_ready, input, 1, instruction memory accepts the fetch at pc this cycle.
REQ-005 SHALL provide port stall, input, 1, pipeline hazard; hold pc when no redirect is present.
REQ-006 SHALL provide port br_taken, input, 1, branch resolved taken this cycle.
REQ-007 SHALL provide port jump, input, 1, jump (J/JAL) resolved this cycle.
REQ-008 SHALL provide port br_pc4, input, 32, PC+4 of the redirecting instruction.
REQ-009 SHALL provide port br_imm, input, 16, branch immediate.
REQ-010 SHALL provide port j_index, input, 26, jump instruction index field.
REQ-011 SHALL provide port pc, output, 32, current fetch address (registered).
REQ-012 SHALL provide port pc_sel, output, 2, PC-mux select: 00 sequential, 01 branch, 10 jump; 11 never driven.
REQ-013 SHALL provide port fetch_req, output, 1, fetch request to instruction memory.
REQ-014 SHALL provide port flush, output, 1, one-cycle pulse to kill the wrong-path instruction in IF/ID.
REQ-015 SHALL provide port redirect_cnt, output, 16, saturating count of applied redirects.

Function
REQ-016 SHALL compute seq = pc + 4, br_tgt = br_pc4 + (sign-extended br_imm << 2), j_tgt = {br_pc4[31:28], j_index, 2'b00}, all modulo 2^32 with no overflow flag.
REQ-017 SHALL implement FSM states BOOT, RUN and PEND, with BOOT entered on reset.
REQ-018 In BOOT, SHALL drive fetch_req=0 and pc_sel=00, hold pc, and go to RUN next cycle unconditionally.
REQ-019 In RUN, SHALL drive fetch_req=1.
REQ-020 In RUN, redirect priority SHALL be jump > br_taken > stall > sequential.
REQ-021 In RUN with imem_ready=1, SHALL load pc with j_tgt (pc_sel=10), br_tgt (pc_sel=01), hold pc (stall, pc_sel=00), or load seq (pc_sel=00), per that priority.
REQ-022 In RUN with imem_ready=0 and no redirect, SHALL hold pc.
REQ-023 In RUN with imem_ready=0 and jump or br_taken asserted, SHALL capture the target and select in pending registers, hold pc, and go to PEND.
REQ-024 In PEND, SHALL drive fetch_req=1 and pc_sel equal to the pending select, and ignore new jump, br_taken and stall.
REQ-025 In PEND, SHALL load pc with the pending target on the first cycle imem_ready=1, then return to RUN.
REQ-026 SHALL assert flush for exactly the one cycle after pc is loaded with a redirect target, whether from RUN or PEND.
REQ-027 SHALL increment redirect_cnt by one on each applied redirect and saturate at 16'hFFFF.
REQ-028 On simultaneous jump and br_taken, SHALL apply the jump only and count it as one redirect.
REQ-029 pc[1:0] SHALL always equal 2'b00 when RESET_PC is word-aligned; no alignment trap is generated.

Reset
REQ-030 When reset=1 at a rising edge, SHALL set pc=RESET_PC, state=BOOT, flush=0, redirect_cnt=0, and clear the pending registers.
REQ-031 Reset SHALL take precedence over every other input, including while in PEND.
REQ-032 During the reset cycle, pc_sel SHALL be 00 and fetch_req SHALL be 0.

Verification
REQ-033 Reset release, imem_ready=1, no redirects: pc sequence SHALL be 0 (BOOT), 0, 4, 8, 12; fetch_req rises one cycle after release.
REQ-034 Branch in RUN: pc=0x40, br_taken=1, br_pc4=0x44, br_imm=16'hFFFE, imem_ready=1 -> next pc=0x3C, pc_sel=01, flush=1 next cycle, redirect_cnt=1.
REQ-035 Jump beats branch: br_pc4=0xA000_0010, j_index=26'h000_0100, jump=1, br_taken=1 -> next pc=0xA000_0400, pc_sel=10, redirect_cnt increments by 1 only.
REQ-036 Redirect while memory busy: jump with imem_ready=0 for 3 cycles -> pc held, state PEND, pc_sel=10; pc loads on the first ready cycle; flush follows that load.
REQ-037 Stall versus redirect: stall=1 with br_taken=1 -> branch applied; stall=1 alone for 2 cycles -> pc held, pc_sel=00.
REQ-038 Saturation and mid-op reset: redirect_cnt preset to 16'hFFFE, then 3 redirects -> count holds at 16'hFFFF; reset asserted in PEND -> pc=RESET_PC, state BOOT, pending target discarded.
